// File: rtl/deadlock_mon_pkg.sv
// Shared types and default sizing for the kernel deadlock monitors.
package deadlock_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    SUSPECT = 2'b01,
    BLOCKED = 2'b10
  } mon_state_e;

  localparam int DEF_AXIS_NUM        = 2;
  localparam int DEF_INST_NUM        = 3;
  localparam int DEF_INST_BLK_NUM    = 1;
  localparam int DEF_BLOCK_THRESHOLD = 8;

endpackage

// File: rtl/deadlock_persist_cnt.sv
// Saturating persistence counter: clear, load-1 and increment controls, terminal flag one below saturation.
module deadlock_persist_cnt #(
  parameter int THRESHOLD = 8,
  parameter int CNT_W     = $clog2(THRESHOLD + 1)
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic load_one,
  input  logic inc,
  output logic term_cnt
);

  logic [CNT_W-1:0] cnt_r;

  // Count consecutive stalled cycles, holding at THRESHOLD once reached.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load_one) begin
      cnt_r <= CNT_W'(1);
    end else if (inc && (cnt_r != CNT_W'(THRESHOLD))) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign term_cnt = (cnt_r == CNT_W'(THRESHOLD - 1));

endmodule

// File: rtl/deadlock_idx0_monitor.sv
// Per-kernel deadlock detector: flags a kernel stuck on one unchanging stall signature.
module deadlock_idx0_monitor
  import deadlock_mon_pkg::*;
#(
  parameter int AXIS_NUM        = DEF_AXIS_NUM,
  parameter int INST_NUM        = DEF_INST_NUM,
  parameter int INST_BLK_NUM    = DEF_INST_BLK_NUM,
  parameter int BLOCK_THRESHOLD = DEF_BLOCK_THRESHOLD
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [AXIS_NUM-1:0]     axis_block_sigs,
  input  logic [INST_NUM-1:0]     inst_idle_sigs,
  input  logic [INST_BLK_NUM-1:0] inst_block_sigs,
  output logic                    block
);

  localparam int SIG_W = AXIS_NUM + INST_BLK_NUM;

  mon_state_e       state_r;
  mon_state_e       state_s;
  logic [SIG_W-1:0] sig_s;
  logic [SIG_W-1:0] sig_q_r;
  logic             stall_raw_s;
  logic             stall_s;
  logic             sig_diff_s;
  logic             term_cnt_s;
  logic             cnt_clr_s;
  logic             cnt_load_s;
  logic             cnt_inc_s;
  logic             sig_load_s;

  // Stall decode; an unknown result counts as not stalled so X never reaches state.
  always_comb begin
    sig_s       = {inst_block_sigs, axis_block_sigs};
    stall_raw_s = ((|axis_block_sigs) | (|inst_block_sigs)) & ~(&inst_idle_sigs);
    stall_s     = (stall_raw_s === 1'b1) ? 1'b1 : 1'b0;
    sig_diff_s  = (sig_s != sig_q_r);
  end

  deadlock_persist_cnt #(
    .THRESHOLD (BLOCK_THRESHOLD)
  ) u_persist_cnt (
    .clock    (clock),
    .reset    (reset),
    .clr      (cnt_clr_s),
    .load_one (cnt_load_s),
    .inc      (cnt_inc_s),
    .term_cnt (term_cnt_s)
  );

  // Next-state and counter/signature control.
  always_comb begin
    state_s    = state_r;
    cnt_clr_s  = 1'b0;
    cnt_load_s = 1'b0;
    cnt_inc_s  = 1'b0;
    sig_load_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (stall_s) begin
          state_s    = SUSPECT;
          cnt_load_s = 1'b1;
          sig_load_s = 1'b1;
        end else begin
          cnt_clr_s = 1'b1;
        end
      end
      SUSPECT, BLOCKED: begin
        if (!stall_s) begin
          state_s   = IDLE;
          cnt_clr_s = 1'b1;
        end else if (sig_diff_s) begin
          // A new signature is progress: restart the persistence window.
          state_s    = SUSPECT;
          cnt_load_s = 1'b1;
          sig_load_s = 1'b1;
        end else if (term_cnt_s || (state_r == BLOCKED)) begin
          state_s   = BLOCKED;
          cnt_inc_s = 1'b1;
        end else begin
          cnt_inc_s = 1'b1;
        end
      end
      default: begin
        state_s   = IDLE;
        cnt_clr_s = 1'b1;
      end
    endcase
  end

  // State, captured signature and the registered block flag.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
      sig_q_r <= {SIG_W{1'b0}};
      block   <= 1'b0;
    end else begin
      state_r <= state_s;
      sig_q_r <= sig_load_s ? sig_s : sig_q_r;
      block   <= (state_s == BLOCKED);
    end
  end

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Directed bench for deadlock_idx0_monitor with a run-length reference model checked every cycle.
module tb_deadlock_idx0_monitor;

  localparam int TH = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] axis_block_sigs = 2'b00;
  logic [2:0] inst_idle_sigs  = 3'b000;
  logic [0:0] inst_block_sigs = 1'b0;
  logic       block;

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  chk_en   = 1'b0;

  int       run_m      = 0;
  logic [2:0] prev_sig_m = 3'b000;
  logic     exp_block_m = 1'b0;

  deadlock_idx0_monitor dut (
    .clock           (clock),
    .reset           (reset),
    .axis_block_sigs (axis_block_sigs),
    .inst_idle_sigs  (inst_idle_sigs),
    .inst_block_sigs (inst_block_sigs),
    .block           (block)
  );

  always #5 clock = ~clock;

  // Length of the current run of stalled cycles sharing one signature.
  function automatic int next_run(input int run, input logic [2:0] prev, input logic [1:0] a,
                                  input logic [2:0] idle, input logic [0:0] ib);
    logic st;
    st = ((a != 2'b00) || (ib != 1'b0)) && (idle != 3'b111);
    if (!st) return 0;
    if ((run > 0) && ({ib, a} == prev)) return (run < 1000) ? run + 1 : run;
    return 1;
  endfunction

  // Reference model: deadlocked once the same stalled signature has persisted TH cycles.
  always @(posedge clock) begin
    if (reset) begin
      run_m       <= 0;
      exp_block_m <= 1'b0;
    end else begin
      run_m       <= next_run(run_m, prev_sig_m, axis_block_sigs, inst_idle_sigs, inst_block_sigs);
      exp_block_m <= (next_run(run_m, prev_sig_m, axis_block_sigs, inst_idle_sigs, inst_block_sigs) >= TH);
      prev_sig_m  <= {inst_block_sigs, axis_block_sigs};
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      n_checks++;
      if (block !== exp_block_m) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: block=%0b expected %0b", $time, block, exp_block_m);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic [2:0] idle, input logic [0:0] ib);
    axis_block_sigs = a;
    inst_idle_sigs  = idle;
    inst_block_sigs = ib;
  endtask

  task automatic check(input string name, input logic exp);
    n_checks++;
    if (block !== exp) begin
      n_fail++;
      $display("FAIL %s: block=%0b expected %0b", name, block, exp);
    end
  endtask

  initial begin
    int edges;
    // 1. reset held with stall present, then latency after release
    drive(2'b11, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycles(1);
      chk_en = 1'b1;
      check("reset_hold", 1'b0);
    end
    reset = 1'b0;
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      cycles(1);
      if (block === 1'b1) begin
        edges = i;
        break;
      end
    end
    n_checks++;
    if (edges != TH) begin
      n_fail++;
      $display("FAIL reset_latency: edges=%0d expected %0d", edges, TH);
    end
    drive(2'b00, 3'b000, 1'b0);
    cycles(1);
    check("reset_drop", 1'b0);

    // 2. threshold
    drive(2'b01, 3'b000, 1'b0);
    cycles(7);
    check("thr_edge7", 1'b0);
    cycles(1);
    check("thr_edge8", 1'b1);
    drive(2'b00, 3'b000, 1'b0);
    cycles(1);
    check("thr_release", 1'b0);

    // 3. glitch restarts the count
    drive(2'b10, 3'b000, 1'b0);
    cycles(7);
    check("glitch_pre", 1'b0);
    drive(2'b00, 3'b000, 1'b0);
    cycles(1);
    check("glitch_gap", 1'b0);
    drive(2'b10, 3'b000, 1'b0);
    cycles(7);
    check("glitch_edge7", 1'b0);
    cycles(1);
    check("glitch_edge8", 1'b1);
    drive(2'b00, 3'b000, 1'b0);
    cycles(1);

    // 4. signature change restarts, and drops block when already blocked
    drive(2'b01, 3'b000, 1'b0);
    cycles(5);
    check("sig_pre", 1'b0);
    drive(2'b10, 3'b000, 1'b0);
    cycles(7);
    check("sig_edge7", 1'b0);
    cycles(1);
    check("sig_edge8", 1'b1);
    drive(2'b01, 3'b000, 1'b0);
    cycles(1);
    check("sig_change_blocked", 1'b0);
    cycles(6);
    check("sig_re_edge7", 1'b0);
    cycles(1);
    check("sig_re_edge8", 1'b1);
    drive(2'b00, 3'b000, 1'b0);
    cycles(1);

    // 5. all-idle never deadlocks; instance block alone does
    drive(2'b11, 3'b111, 1'b0);
    cycles(20);
    check("all_idle", 1'b0);
    drive(2'b00, 3'b000, 1'b1);
    cycles(7);
    check("inst_blk_edge7", 1'b0);
    cycles(1);
    check("inst_blk_edge8", 1'b1);

    // 6. reset while blocked
    reset = 1'b1;
    cycles(1);
    check("reset_mid_blocked", 1'b0);
    reset = 1'b0;
    cycles(7);
    check("post_reset_edge7", 1'b0);
    cycles(1);
    check("post_reset_edge8", 1'b1);

    drive(2'b00, 3'b000, 1'b0);
    cycles(2);
    check("final_idle", 1'b0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
